group_packer: RTL and testbench
===============================

Name: group_packer

Overview:
- Parametrised successor to the capture-path shifter.
- Takes a stream of DW-bit samples built from GN groups of GW bits each.
- Keeps only the groups enabled in cfg_mask, compacts them toward the LSB, and packs successive compacted samples back-to-back into full DW-bit output words.
- Sits between the sample/trigger stage and the capture memory/FIFO, so memory holds only enabled channels; supports back-pressure, flush and clear.

Parameters:
- GW, 8, group width in bits
- GN, 4, number of groups per sample
- DW, GW*GN, sample and output word width (derived; must not be overridden)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- ctl_ena  in  1  enable; input accepted only while high
- ctl_clr  in  1  synchronous clear of all packing state
- ctl_flush  in  1  level; emit any partial word zero-padded
- cfg_mask  in  GN  group enable, bit i = group i
- sti_data  in  DW  input sample
- sti_valid  in  1  input valid
- sti_ready  out  1  input ready
- sto_data  out  DW  packed output word
- sto_valid  out  1  output valid
- sto_ready  in  1  output ready
- sts_empty  out  1  no buffered groups and no pending output

Behaviour:
- State:
  - Accumulator of GN-1 groups, with fill count cnt (0..GN-1).
  - One output register, holding sto_data and sto_valid.
- Reset (rst=1 at a clk edge) and ctl_clr=1 have identical effect: cnt=0, accumulator=0, sto_valid=0, sto_data=0, sts_empty=1. ctl_clr takes priority over every other input in the same cycle.
- Handshake:
  - Transfer occurs on a clk edge where valid&ready.
  - The source holds sti_data stable while sti_valid=1 and sti_ready=0.
  - sto_data/sto_valid stay stable while sto_valid=1 and sto_ready=0.
- Output register is free when sto_valid=0 or sto_ready=1 (combinational drain).
- sti_ready = ctl_ena & ~ctl_clr & ~ctl_flush & output register free.
- Compaction: let k = popcount(cfg_mask). Enabled groups are taken in ascending index and appended at accumulator positions cnt, cnt+1, ... (LSB first).
- Word completion on an accepted sample:
  - If cnt+k >= GN, the lowest GN groups go to the output register (sto_valid=1 the next cycle, i.e. latency 1 clk).
  - The remaining cnt+k-GN groups shift to position 0, and cnt becomes cnt+k-GN.
  - Otherwise cnt becomes cnt+k and no output is produced.
- Since k <= GN and cnt < GN, at most one word is produced per sample; samples may straddle output words.
- k=0 (mask all zeros): samples are accepted and discarded; cnt is unchanged; no output.
- Flush: while ctl_flush=1, no input is accepted.
  - If cnt>0 and the output register is free, the output register is loaded with the cnt groups in the low positions and zeros above, and cnt becomes 0.
  - If cnt=0, nothing happens. Holding flush high is idempotent.
- ctl_ena=0: no input is accepted; the output register still drains; state is otherwise held.
- cfg_mask may change only while sts_empty=1; behaviour otherwise is undefined.
- sts_empty = (cnt==0) & ~sto_valid, registered-state derived (combinational from registers).
- Reset or clear during a stalled output drops the word; no partial transfer occurs.

Test Plan (GW=8, GN=4):
1. mask=4'b1111, one sample 0x44332211 accepted at edge N -> sto_valid=1 with 0x44332211 after edge N, i.e. sampled at edge N+1; sts_empty returns to 1 after the drain.
2. mask=4'b0001, samples 0x000000{11,22,33,44} -> exactly one output word 0x44332211, valid only after the 4th sample; no output after samples 1-3.
3. mask=4'b0101, samples 0xAABBCCDD then 0x11223344 -> single word 0x2244BBDD.
4. mask=4'b0111, samples 0x00030201, 0x00060504, 0x00090807, 0x000C0B0A -> words 0x04030201, 0x08070605, 0x0C0B0A09 in order (straddling).
5. mask=4'b0001, sample 0x00000055, then ctl_flush=1 for 3 cycles -> exactly one word 0x00000055; sti_ready=0 throughout the flush; sts_empty=1 after the drain; mask=4'b0000 with 5 samples -> all accepted, no output.
6. Back-pressure and clear:
   - With mask=4'b1111 and sto_ready=0, after the first word sti_ready=0 and sto_data is held stable for 10 cycles; releasing sto_ready drains words in order with no loss or duplication.
   - Asserting ctl_clr with a word pending gives sto_valid=0, sts_empty=1 the next cycle; rst mid-stream behaves the same.

Source files
------------

// File: rtl/group_packer.sv
// group_packer
//
// Keeps only the GW-bit groups of each DW-bit sample that are enabled in
// cfg_mask, compacts them toward the LSB, and packs successive compacted
// samples back-to-back into full DW-bit output words.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   ctl_ena    input accepted only while high
//   ctl_clr    synchronous clear of all packing state (beats everything)
//   ctl_flush  level; emits any partial word zero-padded, blocks input
//   cfg_mask   group enable, bit i = group i (change only while sts_empty)
//   sti_data   input sample          sti_valid / sti_ready  input handshake
//   sto_data   packed output word    sto_valid / sto_ready  output handshake
//   sts_empty  no buffered groups and no pending output word

module group_packer #(
    parameter int GW = 8,
    parameter int GN = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ctl_ena,
    input  logic               ctl_clr,
    input  logic               ctl_flush,
    input  logic [GN-1:0]      cfg_mask,
    input  logic [GW*GN-1:0]   sti_data,
    input  logic               sti_valid,
    output logic               sti_ready,
    output logic [GW*GN-1:0]   sto_data,
    output logic               sto_valid,
    input  logic               sto_ready,
    output logic               sts_empty
);

    // DW is derived from the group geometry and is deliberately not overridable.
    localparam int DW = GW * GN;
    localparam int AW = (GN - 1) * GW;
    localparam int CW = $clog2(GN);
    // Merge buffer holds up to GN-1 buffered groups plus GN new ones.
    localparam int MN = 2 * GN - 1;
    localparam int IW = $clog2(MN);

    logic [AW-1:0] acc;
    logic [AW-1:0] acc_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [DW-1:0] out_data;
    logic [DW-1:0] out_data_n;
    logic          out_valid;
    logic          out_valid_n;

    logic [GW-1:0] grp [MN];
    logic [IW-1:0] k;
    logic [IW-1:0] total;

    logic out_free;
    logic accept;
    logic flush_go;

    // The output register may be reloaded in the same cycle it drains.
    assign out_free  = ~out_valid | sto_ready;
    assign sti_ready = ctl_ena & ~ctl_clr & ~ctl_flush & out_free;
    assign accept    = sti_valid & sti_ready;
    assign flush_go  = ctl_ena & ctl_flush & ~ctl_clr & (cnt != '0) & out_free;

    assign sto_data  = out_data;
    assign sto_valid = out_valid;
    assign sts_empty = (cnt == '0) & ~out_valid;

    // Build the merged group list: the cnt buffered groups first, then the
    // enabled groups of the incoming sample in ascending index order.
    // Every slot above the merged length is forced to zero so the
    // accumulator never carries stale groups.
    always_comb begin
        for (int i = 0; i < MN; i++) begin
            grp[i] = '0;
        end
        for (int i = 0; i < GN - 1; i++) begin
            if (i < int'(cnt)) begin
                grp[i] = acc[i*GW +: GW];
            end
        end
        k = '0;
        for (int i = 0; i < GN; i++) begin
            if (cfg_mask[i]) begin
                grp[IW'(cnt) + k] = sti_data[i*GW +: GW];
                k = k + 1'b1;
            end
        end
        total = IW'(cnt) + k;
    end

    // Next-state: drain, then either emit a full word from an accepted
    // sample (leftover groups slide to position 0) or emit the zero-padded
    // partial word on flush.
    always_comb begin
        acc_n       = acc;
        cnt_n       = cnt;
        out_data_n  = out_data;
        out_valid_n = out_valid;

        if (out_valid & sto_ready) begin
            out_valid_n = 1'b0;
        end

        if (accept) begin
            if (total >= IW'(GN)) begin
                for (int i = 0; i < GN; i++) begin
                    out_data_n[i*GW +: GW] = grp[i];
                end
                for (int i = 0; i < GN - 1; i++) begin
                    acc_n[i*GW +: GW] = grp[GN + i];
                end
                out_valid_n = 1'b1;
                cnt_n       = CW'(total - IW'(GN));
            end else begin
                for (int i = 0; i < GN - 1; i++) begin
                    acc_n[i*GW +: GW] = grp[i];
                end
                cnt_n = CW'(total);
            end
        end else if (flush_go) begin
            out_data_n  = {{GW{1'b0}}, acc};
            out_valid_n = 1'b1;
            acc_n       = '0;
            cnt_n       = '0;
        end
    end

    // Reset and clear are equivalent; a stalled output word is dropped.
    always_ff @(posedge clk) begin
        if (rst | ctl_clr) begin
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            acc       <= acc_n;
            cnt       <= cnt_n;
            out_data  <= out_data_n;
            out_valid <= out_valid_n;
        end
    end

endmodule

// File: tb/tb_group_packer.sv
// tb_group_packer
//
// Self-checking bench for group_packer (GW=8, GN=4). A byte-queue model
// tracks enabled groups; full words and flushed partial words go into an
// expected-word queue, which a negedge monitor compares against the DUT.
//
// Ports: none (top-level bench).

module tb_group_packer;

    localparam int GW = 8;
    localparam int GN = 4;
    localparam int DW = GW * GN;

    logic          clk = 1'b0;
    logic          rst;
    logic          ctl_ena;
    logic          ctl_clr;
    logic          ctl_flush;
    logic [GN-1:0] cfg_mask;
    logic [DW-1:0] sti_data;
    logic          sti_valid;
    logic          sti_ready;
    logic [DW-1:0] sto_data;
    logic          sto_valid;
    logic          sto_ready;
    logic          sts_empty;

    int n_tests = 0;
    int n_fail  = 0;

    logic [GW-1:0] gq[$];
    logic [DW-1:0] pend[$];
    logic [DW-1:0] got[$];
    bit            last_accept = 1'b0;
    bit            m_free;
    logic [DW-1:0] m_word;

    group_packer #(.GW(GW), .GN(GN)) dut (
        .clk       (clk),
        .rst       (rst),
        .ctl_ena   (ctl_ena),
        .ctl_clr   (ctl_clr),
        .ctl_flush (ctl_flush),
        .cfg_mask  (cfg_mask),
        .sti_data  (sti_data),
        .sti_valid (sti_valid),
        .sti_ready (sti_ready),
        .sto_data  (sto_data),
        .sto_valid (sto_valid),
        .sto_ready (sto_ready),
        .sts_empty (sts_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: groups are a plain byte queue; every GN of them form a word.
    always @(posedge clk) begin
        last_accept = 1'b0;
        if (rst || ctl_clr) begin
            gq.delete();
            pend.delete();
        end else begin
            m_free = (pend.size() == 0) || sto_ready;
            if (ctl_ena && !ctl_flush && m_free && sti_valid) begin
                last_accept = 1'b1;
                for (int i = 0; i < GN; i++) begin
                    if (cfg_mask[i]) gq.push_back(sti_data[i*GW +: GW]);
                end
                if (gq.size() >= GN) begin
                    for (int i = 0; i < GN; i++) m_word[i*GW +: GW] = gq.pop_front();
                    pend.push_back(m_word);
                end
            end else if (ctl_flush && ctl_ena && m_free && gq.size() > 0) begin
                m_word = '0;
                for (int i = 0; i < GN; i++) begin
                    if (gq.size() > 0) m_word[i*GW +: GW] = gq.pop_front();
                end
                pend.push_back(m_word);
            end
        end
    end

    // Monitor: compares outputs and status against the model every cycle
    // and retires the expected word when the DUT transfers it.
    always @(negedge clk) begin
        check("sto_valid", {31'b0, sto_valid}, {31'b0, pend.size() > 0});
        if (pend.size() > 0) check("sto_data", sto_data, pend[0]);
        check("sts_empty", {31'b0, sts_empty}, {31'b0, gq.size() == 0 && pend.size() == 0});
        check("sti_ready", {31'b0, sti_ready},
              {31'b0, ctl_ena && !ctl_clr && !ctl_flush && (pend.size() == 0 || sto_ready)});
        if (pend.size() > 0 && sto_ready && !rst && !ctl_clr) got.push_back(pend.pop_front());
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept();
        int i;
        for (i = 0; i < 200; i++) begin
            step();
            if (last_accept) break;
        end
        if (i == 200) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL accept_timeout: got no accept, expected accept within 200 cycles");
        end
        sti_valid = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [DW-1:0] d);
        sti_data  = d;
        sti_valid = 1'b1;
        wait_accept();
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 50; i++) begin
            if (gq.size() == 0 && pend.size() == 0) break;
            step();
        end
        step();
    endtask

    task automatic drain();
        int i;
        sti_valid = 1'b0;
        ctl_clr   = 1'b0;
        ctl_ena   = 1'b1;
        sto_ready = 1'b1;
        ctl_flush = 1'b1;
        for (i = 0; i < 20; i++) begin
            if (gq.size() == 0 && pend.size() == 0) break;
            step();
        end
        check("drain_done", {31'b0, gq.size() == 0 && pend.size() == 0}, 32'd1);
        ctl_flush = 1'b0;
        step();
        got.delete();
    endtask

    task automatic check_output(input string name, input int n, input logic [DW-1:0] e0,
                                input logic [DW-1:0] e1, input logic [DW-1:0] e2);
        logic [DW-1:0] e [3];
        e[0] = e0;
        e[1] = e1;
        e[2] = e2;
        check({name, "_count"}, DW'(got.size()), DW'(n));
        for (int i = 0; i < n && i < got.size(); i++) check(name, got[i], e[i]);
        got.delete();
    endtask

    initial begin
        rst       = 1'b1;
        ctl_ena   = 1'b0;
        ctl_clr   = 1'b0;
        ctl_flush = 1'b0;
        cfg_mask  = '0;
        sti_data  = '0;
        sti_valid = 1'b0;
        sto_ready = 1'b1;
        step();
        step();
        check("reset_empty", {31'b0, sts_empty}, 32'd1);
        check("reset_valid", {31'b0, sto_valid}, 32'd0);
        rst     = 1'b0;
        ctl_ena = 1'b1;

        // Full mask: one sample in, same word out one clock later.
        cfg_mask = 4'b1111;
        apply_stimulus(32'h44332211);
        wait_idle();
        check_output("t1", 1, 32'h44332211, 0, 0);

        // Single group: four samples make one word, nothing before that.
        cfg_mask = 4'b0001;
        apply_stimulus(32'h00000011);
        apply_stimulus(32'h00000022);
        apply_stimulus(32'h00000033);
        step();
        step();
        check_output("t2_partial", 0, 0, 0, 0);
        apply_stimulus(32'h00000044);
        wait_idle();
        check_output("t2", 1, 32'h44332211, 0, 0);

        // Sparse mask.
        cfg_mask = 4'b0101;
        apply_stimulus(32'hAABBCCDD);
        apply_stimulus(32'h11223344);
        wait_idle();
        check_output("t3", 1, 32'h2244BBDD, 0, 0);

        // Three groups per sample: words straddle samples.
        cfg_mask = 4'b0111;
        apply_stimulus(32'h00030201);
        apply_stimulus(32'h00060504);
        apply_stimulus(32'h00090807);
        apply_stimulus(32'h000C0B0A);
        wait_idle();
        check_output("t4", 3, 32'h04030201, 32'h08070605, 32'h0C0B0A09);

        // Flush held for three cycles emits the partial word once.
        cfg_mask = 4'b0001;
        apply_stimulus(32'h00000055);
        ctl_flush = 1'b1;
        step();
        step();
        step();
        ctl_flush = 1'b0;
        wait_idle();
        check_output("t5_flush", 1, 32'h00000055, 0, 0);

        // Empty mask discards samples.
        cfg_mask = 4'b0000;
        for (int i = 0; i < 5; i++) apply_stimulus(32'hDEAD0000 + 32'(i));
        wait_idle();
        check_output("t5_mask0", 0, 0, 0, 0);

        // Back-pressure: second sample waits ten cycles behind a stalled word.
        cfg_mask  = 4'b1111;
        sto_ready = 1'b0;
        apply_stimulus(32'hA4A3A2A1);
        sti_data  = 32'hB4B3B2B1;
        sti_valid = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("t6_stall_noacc", {31'b0, last_accept}, 32'd0);
        sto_ready = 1'b1;
        wait_accept();
        wait_idle();
        check_output("t6_bp", 2, 32'hA4A3A2A1, 32'hB4B3B2B1, 0);

        // Clear with a pending word drops it.
        sto_ready = 1'b0;
        apply_stimulus(32'hC4C3C2C1);
        step();
        ctl_clr = 1'b1;
        step();
        ctl_clr   = 1'b0;
        sto_ready = 1'b1;
        step();
        check("t6_clr_empty", {31'b0, sts_empty}, 32'd1);
        check_output("t6_clr", 0, 0, 0, 0);

        // Clear discards buffered groups; later packing restarts cleanly.
        cfg_mask = 4'b0001;
        apply_stimulus(32'h00000011);
        apply_stimulus(32'h00000022);
        ctl_clr = 1'b1;
        step();
        ctl_clr = 1'b0;
        apply_stimulus(32'h00000033);
        apply_stimulus(32'h00000044);
        apply_stimulus(32'h00000055);
        apply_stimulus(32'h00000066);
        wait_idle();
        check_output("t6_clr_partial", 1, 32'h66554433, 0, 0);

        // Reset mid-stream behaves like clear.
        cfg_mask  = 4'b1111;
        sto_ready = 1'b0;
        apply_stimulus(32'hD4D3D2D1);
        rst = 1'b1;
        step();
        rst       = 1'b0;
        sto_ready = 1'b1;
        step();
        check("t6_rst_valid", {31'b0, sto_valid}, 32'd0);
        check_output("t6_rst", 0, 0, 0, 0);

        // Randomized blocks; mask only changes after a full drain.
        for (int blk = 0; blk < 120; blk++) begin
            drain();
            cfg_mask = GN'($urandom);
            for (int cyc = 0; cyc < 40; cyc++) begin
                if (!(sti_valid && !last_accept)) begin
                    sti_valid = ($urandom_range(0, 3) != 0);
                    sti_data  = $urandom;
                end
                sto_ready = ($urandom_range(0, 3) != 0);
                ctl_ena   = ($urandom_range(0, 7) != 0);
                ctl_flush = ctl_ena && ($urandom_range(0, 15) == 0);
                ctl_clr   = ($urandom_range(0, 31) == 0);
                step();
            end
            sti_valid = 1'b0;
            ctl_clr   = 1'b0;
            ctl_flush = 1'b0;
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
